// File: rtl/adder_stage1_pkg.sv
// Shared widths, width-select encodings and the stage-1 entry layout for the prefix adder.
// Latency: n/a (types and helpers only). Backpressure: n/a.
package adder_stage1_pkg;

    localparam int LEN_DATA = 31;
    localparam int W        = LEN_DATA + 1;
    localparam int ENTRY_W  = 4 * W + 1;

    typedef enum logic [1:0] {
        WSEL_8    = 2'b00,
        WSEL_16   = 2'b01,
        WSEL_32   = 2'b10,
        WSEL_FULL = 2'b11
    } wsel_e;

    typedef logic [LEN_DATA:0] data_t;

    // Field order fixes the bit layout of one buffered entry.
    typedef struct packed {
        data_t g;
        data_t p;
        data_t h;
        data_t mask;
        logic  c0;
    } entry_t;

    // Lanes below the active width are 1. Widths above W are clamped to W.
    function automatic data_t lane_mask(input logic [1:0] width_sel);
        int    active_w;
        data_t m;
        case (width_sel)
            WSEL_8:  active_w = 8;
            WSEL_16: active_w = 16;
            WSEL_32: active_w = 32;
            default: active_w = W;
        endcase
        if (active_w > W) active_w = W;
        m = '0;
        for (int i = 0; i < W; i++) m[i] = (i < active_w);
        return m;
    endfunction

endpackage

// File: rtl/adder_stage1_if.sv
// Operand/result bus between the ALU operand mux, adder_stage1 and adder_stage2.
// Latency: n/a. Backpressure: valid/ready on both the operand side and the result side.
interface adder_stage1_if;
    import adder_stage1_pkg::*;

    logic        in_valid;
    logic        in_ready;
    data_t       op_a;
    data_t       op_b;
    logic        op_sub;
    logic        cin;
    logic [1:0]  width_sel;

    logic        out_valid;
    logic        out_ready;
    data_t       generate_out;
    data_t       propogate_out;
    data_t       half_sum_out;
    data_t       mask_out;
    logic        cin_out;

    // The stage itself: consumes operands, produces the g/p/h/mask bundle.
    modport slave (
        input  in_valid, op_a, op_b, op_sub, cin, width_sel, out_ready,
        output in_ready, out_valid, generate_out, propogate_out, half_sum_out, mask_out, cin_out
    );

    // Surrounding logic: drives operands and accepts results.
    modport master (
        output in_valid, op_a, op_b, op_sub, cin, width_sel, out_ready,
        input  in_ready, out_valid, generate_out, propogate_out, half_sum_out, mask_out, cin_out
    );

endinterface

// File: rtl/adder_skid_buf.sv
// Generic 2-entry valid/ready buffer; outputs always present the head entry straight from a register.
// Latency: 1 cycle from accepted input to out_vld when empty; 1 entry/cycle throughput.
// Backpressure: in_rdy drops only when both entries are full; contents are held while out_rdy is low.
module adder_skid_buf #(
    parameter int ENTRY_W = 1,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [ENTRY_W-1:0] in_dat,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [ENTRY_W-1:0] out_dat
);

    if (DEPTH != 2) begin : g_bad_depth
        $error("adder_skid_buf supports DEPTH == 2 only");
    end

    logic [1:0]         count;
    logic [ENTRY_W-1:0] head_q;
    logic [ENTRY_W-1:0] tail_q;
    logic               push;
    logic               pop;

    assign in_rdy  = (count != 2'd2);
    assign out_vld = (count != 2'd0);
    assign out_dat = head_q;
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else if (push && pop) begin
            // Only reachable with count == 1: the new entry replaces the departing head.
            head_q <= in_dat;
        end else if (push) begin
            if (count == 2'd0) head_q <= in_dat;
            else               tail_q <= in_dat;
            count <= count + 2'd1;
        end else if (pop) begin
            head_q <= tail_q;
            count  <= count - 2'd1;
        end
    end

endmodule

// File: rtl/adder_stage1.sv
// Prefix-adder stage 1: forms per-bit generate/propagate/half-sum plus lane mask and buffers them.
// Latency: 1 cycle (registered outputs), 1 op/cycle. Backpressure: 2-entry skid, in_ready low when full.
module adder_stage1
    import adder_stage1_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    adder_stage1_if.slave  bus
);

    data_t  b_eff;
    logic   c0;
    data_t  g_raw;
    data_t  p_raw;
    entry_t in_ent;
    entry_t head;
    logic [ENTRY_W-1:0] head_dat;

    assign b_eff = bus.op_sub ? ~bus.op_b : bus.op_b;
    assign c0    = bus.op_sub | bus.cin;
    assign g_raw = bus.op_a & b_eff;
    assign p_raw = bus.op_a | b_eff;

    // Carry-in is folded into bit 0 so stage 2 never needs c0 separately in the prefix tree.
    always_comb begin
        in_ent      = '0;
        in_ent.g    = g_raw;
        in_ent.g[0] = g_raw[0] | (p_raw[0] & c0);
        in_ent.p    = p_raw;
        in_ent.h    = bus.op_a ^ b_eff;
        in_ent.mask = lane_mask(bus.width_sel);
        in_ent.c0   = c0;
    end

    adder_skid_buf #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (bus.in_valid),
        .in_rdy  (bus.in_ready),
        .in_dat  (in_ent),
        .out_vld (bus.out_valid),
        .out_rdy (bus.out_ready),
        .out_dat (head_dat)
    );

    assign head              = entry_t'(head_dat);
    assign bus.generate_out  = head.g;
    assign bus.propogate_out = head.p;
    assign bus.half_sum_out  = head.h;
    assign bus.mask_out      = head.mask;
    assign bus.cin_out       = head.c0;

endmodule

// File: tb/tb_adder_stage1.sv
// Directed-vector bench for adder_stage1: reset, add/sub forms, backpressure, streaming, mid-flight reset.
module tb_adder_stage1;
    import adder_stage1_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    adder_stage1_if bus();

    adder_stage1 #(.DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference bundle {g,p,h,mask,c0} for one operation.
    function automatic logic [128:0] ref_bundle(input logic [31:0] a, input logic [31:0] b,
                                                input logic sub, input logic ci, input logic [1:0] ws);
        logic [31:0] bb, g, p, h, m;
        logic        c;
        int          aw;
        bb = sub ? ~b : b;
        c  = sub | ci;
        g  = a & bb;
        p  = a | bb;
        h  = a ^ bb;
        if (p[0] && c) g[0] = 1'b1;
        aw = (ws == 2'b11) ? 32 : ((8 << ws) > 32 ? 32 : (8 << ws));
        m  = (aw >= 32) ? 32'hFFFF_FFFF : ((32'h1 << aw) - 32'h1);
        return {g, p, h, m, c};
    endfunction

    function automatic logic [128:0] dut_bundle();
        return {bus.generate_out, bus.propogate_out, bus.half_sum_out, bus.mask_out, bus.cin_out};
    endfunction

    task automatic drive(input logic vld, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic ci, input logic [1:0] ws);
        bus.in_valid  = vld;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.op_sub    = sub;
        bus.cin       = ci;
        bus.width_sel = ws;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0]  ra, rb;
        logic         rs, rc;
        logic [1:0]   rw;
        logic [128:0] exp_b;

        drive(1'b0, '0, '0, 1'b0, 1'b0, 2'b11);
        bus.out_ready = 1'b0;

        // 1: reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready",  bus.in_ready,  1'b1);
        chk("rst_g",    bus.generate_out,  32'h0);
        chk("rst_p",    bus.propogate_out, 32'h0);
        chk("rst_h",    bus.half_sum_out,  32'h0);
        chk("rst_mask", bus.mask_out,      32'h0);
        chk("rst_cin",  bus.cin_out,       1'b0);

        // 2: add, full width
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h0000_00F0, 32'h0000_0F0F, 1'b0, 1'b0, 2'b11);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 2'b11);
        chk("add_valid", bus.out_valid,     1'b1);
        chk("add_g",     bus.generate_out,  32'h0000_0000);
        chk("add_p",     bus.propogate_out, 32'h0000_0FFF);
        chk("add_h",     bus.half_sum_out,  32'h0000_0FFF);
        chk("add_mask",  bus.mask_out,      32'hFFFF_FFFF);
        chk("add_cin",   bus.cin_out,       1'b0);
        tick();
        chk("add_drained", bus.out_valid, 1'b0);

        // 3: subtract, 8-bit lanes; bit 0 generate picks up the forced carry-in
        drive(1'b1, 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 2'b00);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 2'b11);
        chk("sub_valid", bus.out_valid,     1'b1);
        chk("sub_g",     bus.generate_out,  32'h0000_0005);
        chk("sub_p",     bus.propogate_out, 32'hFFFF_FFFD);
        chk("sub_h",     bus.half_sum_out,  32'hFFFF_FFF9);
        chk("sub_mask",  bus.mask_out,      32'h0000_00FF);
        chk("sub_cin",   bus.cin_out,       1'b1);
        tick();

        // 4: backpressure with three ops (h identifies each op)
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 2'b11);
        tick();
        chk("bp_rdy_after1", bus.in_ready, 1'b1);
        drive(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 2'b01);
        tick();
        chk("bp_rdy_after2", bus.in_ready, 1'b0);
        chk("bp_head1_h", bus.half_sum_out, 32'h0000_0003);
        drive(1'b1, 32'h0000_0100, 32'h0000_0200, 1'b0, 1'b1, 2'b10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stall_rdy",  bus.in_ready, 1'b0);
            chk("bp_stall_head", dut_bundle(), ref_bundle(32'h1, 32'h2, 1'b0, 1'b0, 2'b11));
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_head2", dut_bundle(), ref_bundle(32'h10, 32'h20, 1'b0, 1'b0, 2'b01));
        chk("bp_mask16", bus.mask_out, 32'h0000_FFFF);
        chk("bp_rdy_reopen", bus.in_ready, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 2'b11);
        chk("bp_head3", dut_bundle(), ref_bundle(32'h100, 32'h200, 1'b0, 1'b1, 2'b10));
        chk("bp_head3_h", bus.half_sum_out, 32'h0000_0300);
        chk("bp_mask32", bus.mask_out, 32'hFFFF_FFFF);
        chk("bp_valid3", bus.out_valid, 1'b1);
        tick();
        chk("bp_empty", bus.out_valid, 1'b0);

        // 5: streaming, one op per cycle
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            rw = 2'(i % 4);
            exp_b = ref_bundle(ra, rb, rs, rc, rw);
            chk("stream_in_ready", bus.in_ready, 1'b1);
            drive(1'b1, ra, rb, rs, rc, rw);
            tick();
            chk("stream_valid", bus.out_valid, 1'b1);
            chk("stream_bundle", dut_bundle(), exp_b);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 2'b11);
        tick();
        chk("stream_drained", bus.out_valid, 1'b0);

        // 6: reset while full, with a push and pop offered in the same cycle
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hAAAA_0000, 32'h0000_5555, 1'b0, 1'b0, 2'b11);
        tick();
        drive(1'b1, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 2'b11);
        tick();
        chk("mid_full", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 2'b11);
        chk("mid_out_valid", bus.out_valid, 1'b0);
        chk("mid_in_ready",  bus.in_ready,  1'b1);
        chk("mid_bundle",    dut_bundle(),  129'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("mid_no_ghost", bus.out_valid, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
